// File: rtl/hazard_stall_ctrl.sv
// Pipeline front-end control for the 5-stage MIPS core: load-use and ID-branch
// data hazards, taken-branch/jump flush, multi-cycle MDU hold and a stall counter.
module hazard_stall_ctrl #(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rt,
    input  logic                   id_is_branch,
    input  logic                   branch_taken,
    input  logic                   jump,
    input  logic                   ex_mem_read,
    input  logic                   ex_reg_write,
    input  logic [4:0]             ex_wr_reg,
    input  logic                   mem_mem_read,
    input  logic [4:0]             mem_wr_reg,
    input  logic                   ex_mdu_start,
    output logic                   pc_write,
    output logic                   if_id_freeze,
    output logic                   if_flush,
    output logic                   id_ex_bubble,
    output logic                   ex_hold,
    output logic                   mdu_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAT_M1 = 8'(MDU_LATENCY - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   mdu_busy_q, mdu_busy_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    // Index 0 = EX stage destination, index 1 = MEM stage destination.
    logic [1:0][4:0] stage_wr;
    logic [1:0]      match;

    assign stage_wr[0] = ex_wr_reg;
    assign stage_wr[1] = mem_wr_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_match
            assign match[gi] = (stage_wr[gi] != 5'd0) &&
                               ((stage_wr[gi] == id_rs) ||
                                (id_uses_rt && (stage_wr[gi] == id_rt)));
        end
    endgenerate

    logic load_use, br_stall, data_stall, mdu_stall, redirect;

    always_comb begin
        load_use   = ex_mem_read && match[0];
        br_stall   = id_is_branch && ((ex_reg_write && match[0]) ||
                                      (mem_mem_read && match[1]));
        data_stall = load_use || br_stall;
        mdu_stall  = ((state_q == IDLE) && ex_mdu_start) || (state_q == MDU_BUSY);
        redirect   = jump || (id_is_branch && branch_taken);
    end

    // Stalls take precedence over redirect so a branch re-resolves after the stall.
    always_comb begin
        pc_write     = 1'b1;
        if_id_freeze = 1'b0;
        if_flush     = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_flush     = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mdu_stall) begin
            pc_write     = 1'b0;
            if_id_freeze = 1'b1;
            ex_hold      = 1'b1;
        end else if (data_stall) begin
            pc_write     = 1'b0;
            if_id_freeze = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (redirect) begin
            if_flush     = 1'b1;
        end
    end

    // MDU_DONE ignores ex_mdu_start: the finished instruction still drives it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ex_mdu_start) begin
                    if (MDU_LATENCY == 1) begin
                        state_d = MDU_DONE;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = MDU_BUSY;
                    end
                end
            end
            MDU_BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = MDU_DONE;
                end
            end
            MDU_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        mdu_busy_d = (state_d == MDU_BUSY);
        stall_d    = stall_q;
        if (!pc_write && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            mdu_busy_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mdu_busy_q <= mdu_busy_d;
            stall_q    <= stall_d;
        end
    end

    assign mdu_busy     = mdu_busy_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed and random checks of hazard_stall_ctrl against a cycle-level model
// that tracks remaining MDU cycles and counts stalls with plain integers.
module tb_hazard_stall_ctrl;

    localparam int LAT = 4;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_wr_reg, mem_wr_reg;
    logic       id_uses_rt, id_is_branch, branch_taken, jump;
    logic       ex_mem_read, ex_reg_write, mem_mem_read, ex_mdu_start;
    logic       pc_write, if_id_freeze, if_flush, id_ex_bubble, ex_hold, mdu_busy;
    logic [15:0] stall_cycles;
    logic       s_pc_write, s_if_id_freeze, s_if_flush, s_id_ex_bubble, s_ex_hold, s_mdu_busy;
    logic [3:0] s_stall_cycles;

    hazard_stall_ctrl #(.MDU_LATENCY(LAT), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .branch_taken(branch_taken), .jump(jump),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_wr_reg(ex_wr_reg),
        .mem_mem_read(mem_mem_read), .mem_wr_reg(mem_wr_reg), .ex_mdu_start(ex_mdu_start),
        .pc_write(pc_write), .if_id_freeze(if_id_freeze), .if_flush(if_flush),
        .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .mdu_busy(mdu_busy),
        .stall_cycles(stall_cycles)
    );

    hazard_stall_ctrl #(.MDU_LATENCY(LAT), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .branch_taken(branch_taken), .jump(jump),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_wr_reg(ex_wr_reg),
        .mem_mem_read(mem_mem_read), .mem_wr_reg(mem_wr_reg), .ex_mdu_start(ex_mdu_start),
        .pc_write(s_pc_write), .if_id_freeze(s_if_id_freeze), .if_flush(s_if_flush),
        .id_ex_bubble(s_id_ex_bubble), .ex_hold(s_ex_hold), .mdu_busy(s_mdu_busy),
        .stall_cycles(s_stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // Reference state: MDU stall cycles still owed, "done" cycle pending, stall totals.
    int left = 0;
    bit done = 0;
    bit busy_m = 0;
    int st16 = 0;
    int st4 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_is_branch = 0; branch_taken = 0;
        jump = 0; ex_mem_read = 0; ex_reg_write = 0; ex_wr_reg = 0;
        mem_mem_read = 0; mem_wr_reg = 0; ex_mdu_start = 0;
    endtask

    // Check one cycle against the model, then advance through the clock edge.
    task automatic cycle();
        bit m_ex, m_mem, ds, ms, rd;
        bit e_pc, e_frz, e_fl, e_bub, e_hold;
        m_ex  = (ex_wr_reg != 0) && (ex_wr_reg == id_rs || (id_uses_rt && ex_wr_reg == id_rt));
        m_mem = (mem_wr_reg != 0) && (mem_wr_reg == id_rs || (id_uses_rt && mem_wr_reg == id_rt));
        ds = (ex_mem_read && m_ex) ||
             (id_is_branch && ((ex_reg_write && m_ex) || (mem_mem_read && m_mem)));
        ms = (left > 0) || (!done && ex_mdu_start);
        rd = jump || (id_is_branch && branch_taken);
        {e_pc, e_frz, e_fl, e_bub, e_hold} = rst ? 5'b00110 :
                                             ms  ? 5'b01001 :
                                             ds  ? 5'b01010 :
                                             rd  ? 5'b10100 : 5'b10000;
        #1;
        chk("pc_write", pc_write, e_pc);
        chk("if_id_freeze", if_id_freeze, e_frz);
        chk("if_flush", if_flush, e_fl);
        chk("id_ex_bubble", id_ex_bubble, e_bub);
        chk("ex_hold", ex_hold, e_hold);
        chk("mdu_busy", mdu_busy, busy_m);
        chk("stall_cycles", stall_cycles, st16);
        chk("stall_cycles_w4", s_stall_cycles, st4);
        @(posedge clk);
        if (rst) begin
            left = 0; done = 0; st16 = 0; st4 = 0;
        end else begin
            if (!e_pc) begin
                if (st16 < 65535) st16++;
                if (st4 < 15) st4++;
            end
            if (left > 0) begin
                left--;
                done = (left == 0);
            end else if (!done && ex_mdu_start) begin
                left = LAT - 1;
                done = (left == 0);
            end else begin
                done = 0;
            end
        end
        busy_m = (left > 0);
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        cycle();
        cycle();

        // Reset state
        rst = 0;
        #1;
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_mdu_busy", mdu_busy, 0);
        chk("rst_pc_write", pc_write, 1);
        cycle();

        // Load-use: one stall cycle
        ex_mem_read = 1; ex_wr_reg = 8; id_rs = 8;
        #1;
        chk("lu_pc_write", pc_write, 0);
        chk("lu_freeze", if_id_freeze, 1);
        chk("lu_bubble", id_ex_bubble, 1);
        cycle();
        clear_inputs();
        #1;
        chk("lu_run_pc", pc_write, 1);
        chk("lu_count", stall_cycles, 1);
        cycle();

        // Branch after load: two stalls then flush
        id_is_branch = 1; id_rt = 9; id_uses_rt = 1; branch_taken = 1;
        ex_mem_read = 1; ex_reg_write = 1; ex_wr_reg = 9;
        #1;
        chk("bl0_pc", pc_write, 0);
        chk("bl0_flush", if_flush, 0);
        cycle();
        ex_mem_read = 0; ex_reg_write = 0; ex_wr_reg = 0;
        mem_mem_read = 1; mem_wr_reg = 9;
        #1;
        chk("bl1_pc", pc_write, 0);
        chk("bl1_flush", if_flush, 0);
        cycle();
        mem_mem_read = 0; mem_wr_reg = 0;
        #1;
        chk("bl2_pc", pc_write, 1);
        chk("bl2_flush", if_flush, 1);
        chk("bl_count", stall_cycles, 3);
        cycle();
        clear_inputs();

        // MDU held for LAT cycles, start held one extra cycle
        ex_mdu_start = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("mdu_hold_%0d", i), ex_hold, (i < 4) ? 1 : 0);
            chk($sformatf("mdu_busy_%0d", i), mdu_busy, (i >= 1 && i <= 3) ? 1 : 0);
            cycle();
        end
        ex_mdu_start = 0;
        #1;
        chk("mdu_after_hold", ex_hold, 0);
        chk("mdu_count", stall_cycles, 7);
        cycle();

        // Register 0 never matches; jump flushes
        ex_mem_read = 1; ex_wr_reg = 0; id_rs = 0; jump = 1;
        #1;
        chk("r0_pc", pc_write, 1);
        chk("r0_flush", if_flush, 1);
        chk("r0_freeze", if_id_freeze, 0);
        cycle();
        clear_inputs();

        // Reset during MDU_BUSY
        ex_mdu_start = 1;
        cycle();
        cycle();
        rst = 1; ex_mdu_start = 0;
        #1;
        chk("rmdu_flush", if_flush, 1);
        chk("rmdu_bubble", id_ex_bubble, 1);
        chk("rmdu_pc", pc_write, 0);
        cycle();
        rst = 0;
        #1;
        chk("rmdu_busy", mdu_busy, 0);
        chk("rmdu_count", stall_cycles, 0);
        chk("rmdu_hold", ex_hold, 0);
        cycle();

        // Saturation of the 4-bit counter
        ex_mem_read = 1; ex_wr_reg = 5; id_rs = 5;
        for (int i = 0; i < 20; i++) cycle();
        clear_inputs();
        #1;
        chk("sat_w4", s_stall_cycles, 15);
        chk("sat_w16", stall_cycles, 20);
        cycle();

        // Random stimulus against the model
        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 59) == 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            id_is_branch = ($urandom_range(0, 2) == 0);
            branch_taken = 1'($urandom_range(0, 1));
            jump         = ($urandom_range(0, 4) == 0);
            ex_mem_read  = ($urandom_range(0, 2) == 0);
            ex_reg_write = 1'($urandom_range(0, 1));
            ex_wr_reg    = 5'($urandom_range(0, 3));
            mem_mem_read = ($urandom_range(0, 2) == 0);
            mem_wr_reg   = 5'($urandom_range(0, 3));
            ex_mdu_start = (left > 0 || done) ? 1'($urandom_range(0, 1))
                                              : ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
